// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed six-digit 7-segment back end.
// Latches the display frame once per scan, inserts blank gaps between
// digits against ghosting, and blinks the display and drives the buzzer
// while the latched alarm is active.
module seg_scan_driver #(
    parameter int DIGIT_CYCLES = 1000,
    parameter int BLANK_CYCLES = 4,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [47:0] out,
    input  logic [7:0]  o_m,
    input  logic        alarm,
    output logic [7:0]  seg_n,
    output logic [5:0]  an_n,
    output logic [7:0]  led,
    output logic        buzz,
    output logic        frame_start
);

    localparam int CNT_W = $clog2(DIGIT_CYCLES + 1);
    localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [BLK_W-1:0] BLINK_LAST = BLK_W'(BLINK_FRAMES - 1);

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [47:0]       shadow_q;
    logic              alarmL_q, alarmL_d;
    logic              phaseOn_q, phaseOn_d;
    logic [BLK_W-1:0]  blinkCnt_q, blinkCnt_d;
    logic              latch;

    // The frame is latched at the very start of digit 0's blank gap, so a
    // scan always shows one consistent frame.
    assign latch = (state_q == BLANK) && (idx_q == 3'd0) && (cnt_q == '0);

    // Slot sequencing: blank gap first, then drive, then advance to the next digit.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q + 1'b1;
        case (state_q)
            BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == SLOT_LAST) begin
                    state_d = BLANK;
                    cnt_d   = '0;
                    idx_d   = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
                end
            end
            default: begin
                state_d = BLANK;
                cnt_d   = '0;
                idx_d   = 3'd0;
            end
        endcase
    end

    // Blink sequencing only moves at a frame latch; the first alarmed frame is ON.
    always_comb begin
        alarmL_d   = alarmL_q;
        phaseOn_d  = phaseOn_q;
        blinkCnt_d = blinkCnt_q;
        if (latch) begin
            alarmL_d = alarm;
            if (!alarm) begin
                phaseOn_d  = 1'b1;
                blinkCnt_d = '0;
            end else if (alarmL_q) begin
                if (blinkCnt_q == BLINK_LAST) begin
                    phaseOn_d  = ~phaseOn_q;
                    blinkCnt_d = '0;
                end else begin
                    blinkCnt_d = blinkCnt_q + 1'b1;
                end
            end
        end
    end

    // Scan state, shadow frame and all registered outputs; anode and segment
    // lines are loaded on the same edge from the same slot so they never disagree.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= BLANK;
            idx_q       <= 3'd0;
            cnt_q       <= '0;
            shadow_q    <= 48'h0;
            alarmL_q    <= 1'b0;
            phaseOn_q   <= 1'b1;
            blinkCnt_q  <= '0;
            seg_n       <= 8'hFF;
            an_n        <= 6'h3F;
            led         <= 8'h00;
            buzz        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            alarmL_q    <= alarmL_d;
            phaseOn_q   <= phaseOn_d;
            blinkCnt_q  <= blinkCnt_d;
            frame_start <= latch;
            buzz        <= alarmL_d & phaseOn_d;
            if (latch) begin
                shadow_q <= out;
                led      <= o_m;
            end
            if (state_q == DRIVE) begin
                an_n <= ~(6'b000001 << idx_q);
                if (alarmL_q && !phaseOn_q) begin
                    seg_n <= 8'hFF;
                end else begin
                    seg_n <= ~shadow_q[{idx_q, 3'b000} +: 8];
                end
            end else begin
                an_n  <= 6'h3F;
                seg_n <= 8'hFF;
            end
        end
    end

endmodule
